// File: rtl/cd_div_pkg.sv
// Shared types and constants for the cd2_div restoring divider.
// The CD_BORROW_DISREGARD_EN build macro selects the trial-subtraction variant in cd_trial_sub.
package cd_div_pkg;

  localparam int unsigned DVD_W = 12;
  localparam int unsigned DVS_W = 4;
  localparam int unsigned Q_W   = 8;
  localparam int unsigned ITER  = 8;
  localparam int unsigned CNT_W = 3;

  localparam logic [Q_W-1:0]   Q_OVF = 8'hFF;
  localparam logic [DVS_W-1:0] R_OVF = 4'hF;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  // The quotient fits in Q_W bits only if the top nibble is below the divisor.
  function automatic logic is_ovf(input logic [DVD_W-1:0] dvd, input logic [DVS_W-1:0] dvs);
    return dvd[DVD_W-1:Q_W] >= dvs;
  endfunction

endpackage

// File: rtl/cd_trial_sub.sv
// One trial subtraction of the restoring divider: diff = minuend - subtrahend, ge = no borrow.
// With CD_BORROW_DISREGARD_EN defined, the borrow out of bit 1 is dropped (approximate mode).
module cd_trial_sub
  import cd_div_pkg::*;
(
  input  logic [DVS_W:0]   minuend,
  input  logic [DVS_W-1:0] subtrahend,
  output logic [DVS_W:0]   diff,
  output logic             ge
);

`ifdef CD_BORROW_DISREGARD_EN
  logic [3:0] hi;

  always_comb begin
    hi   = {1'b0, minuend[4:2]} - {2'b00, subtrahend[3:2]};
    diff = {hi[2:0], minuend[1:0] ^ subtrahend[1:0]};
    ge   = ~hi[3];
  end
`else
  logic [DVS_W+1:0] full;

  always_comb begin
    full = {1'b0, minuend} - {2'b00, subtrahend};
    diff = full[DVS_W:0];
    ge   = ~full[DVS_W+1];
  end
`endif

endmodule

// File: rtl/cd2_div.sv
// 12/4-bit unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Trial-subtraction variant selected by CD_BORROW_DISREGARD_EN (see cd_trial_sub).
module cd2_div
  import cd_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DVS_W-1:0]   rem_q;
  logic [DVS_W-1:0]   dvs_q;
  logic [Q_W-1:0]     dq_q;
  logic               ovf_q;

  logic [DVS_W:0]     trial;
  logic [DVS_W:0]     diff;
  logic               ge;
  logic               unused_diff;

  assign trial       = {rem_q, dq_q[Q_W-1]};
  // diff[4] is always 0 whenever ge is set, so only the low nibble is kept.
  assign unused_diff = diff[DVS_W];

  cd_trial_sub u_trial_sub (
    .minuend    (trial),
    .subtrahend (dvs_q),
    .diff       (diff),
    .ge         (ge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = is_ovf(dividend, divisor) ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // dq_q shifts remaining dividend bits out at the top and quotient bits in at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      dq_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            cnt_q <= '0;
            dvs_q <= divisor;
            if (is_ovf(dividend, divisor)) begin
              dq_q  <= Q_OVF;
              rem_q <= R_OVF;
              ovf_q <= 1'b1;
            end else begin
              dq_q  <= dividend[Q_W-1:0];
              rem_q <= dividend[DVD_W-1:Q_W];
              ovf_q <= 1'b0;
            end
          end
        end
        StCalc: begin
          dq_q  <= {dq_q[Q_W-2:0], ge};
          rem_q <= ge ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = dq_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cd2_div.sv
// Directed self-checking bench for cd2_div; expectations are hand-computed per vector.
// Builds with or without CD_BORROW_DISREGARD_EN; mode-dependent vectors are selected accordingly.
module tb_cd2_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] dividend;
  logic [3:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [3:0]  remainder;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CD_BORROW_DISREGARD_EN
  localparam logic [3:0] REM_6_5 = 4'd3;
`else
  localparam logic [3:0] REM_6_5 = 4'd1;
`endif

  always #5 clk = ~clk;

  cd2_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one operand pair, then count cycles until out_valid (bounded).
  task automatic do_op(input string tag, input logic [11:0] dvd, input logic [3:0] dvs,
                       output int lat);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result(input string tag, input logic [7:0] exp_q);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_novalid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_hold_q"}, 32'(quotient), 32'(exp_q));
  endtask

  task automatic vector(input string tag, input logic [11:0] dvd, input logic [3:0] dvs,
                        input logic [7:0] exp_q, input logic [3:0] exp_r, input logic exp_o,
                        input int exp_lat);
    int lat;
    do_op(tag, dvd, dvs, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_q"}, 32'(quotient), 32'(exp_q));
    check({tag, "_r"}, 32'(remainder), 32'(exp_r));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
    release_result(tag, exp_q);
  endtask

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

`ifndef CD_BORROW_DISREGARD_EN
    vector("d1000_7", 12'd1000, 4'd7, 8'd142, 4'd6, 1'b0, 9);
    vector("d255_1", 12'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9);
    vector("d100_3", 12'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9);
    vector("d2047_8", 12'd2047, 4'd8, 8'd255, 4'd7, 1'b0, 9);
`endif
    vector("d1000_4", 12'd1000, 4'd4, 8'd250, 4'd0, 1'b0, 9);
    vector("ovf_4095_15", 12'd4095, 4'd15, 8'hFF, 4'hF, 1'b1, 1);
    vector("ovf_4095_0", 12'd4095, 4'd0, 8'hFF, 4'hF, 1'b1, 1);
    vector("ovf_2048_8", 12'd2048, 4'd8, 8'hFF, 4'hF, 1'b1, 1);
    vector("ovf_0_0", 12'd0, 4'd0, 8'hFF, 4'hF, 1'b1, 1);

    // Backpressure: hold DONE with in_valid asserted; it must be ignored there and in the
    // handshake cycle, then accepted from IDLE.
    do_op("bp", 12'd1000, 4'd4, lat);
    check("bp_lat", 32'(lat), 32'd9);
    in_valid = 1'b1;
    dividend = 12'd6;
    divisor  = 4'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_q", 32'(quotient), 32'd250);
      check("bp_r", 32'(remainder), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_hs_idle", 32'(in_ready), 32'd1);
    check("bp_hs_novalid", 32'(out_valid), 32'd0);
    check("bp_hs_q", 32'(quotient), 32'd250);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_next_lat", 32'(lat), 32'd9);
    check("bp_next_q", 32'(quotient), 32'd1);
    check("bp_next_r", 32'(remainder), 32'(REM_6_5));
    release_result("bp_next", 8'd1);

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 12'd1000;
    divisor  = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_q", 32'(quotient), 32'd0);
    check("mid_rst_r", 32'(remainder), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("mid_rst_no_valid", 32'(seen), 32'd0);
    vector("d6_5", 12'd6, 4'd5, 8'd1, REM_6_5, 1'b0, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
